frame_packer: RTL



---
 rtl/frame_packer_pkg.sv | 24 ++
 rtl/packer_fifo.sv | 78 +++++++
 rtl/frame_packer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_packer_pkg.sv
// rtl/frame_packer_pkg.sv - shared FSM encoding and sync-header defaults for frame_packer
//
// Purpose: types and constants shared by frame_packer and packer_fifo.
// Contents:
//   state_e    - pacing FSM state encoding
//   SYNC_HDR0  - default first sync byte
//   SYNC_HDR1  - default second sync byte
//   ENTRY_W    - FIFO entry width: {marker, byte}
package frame_packer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        SEND = 3'd2,
        ACK  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [7:0] SYNC_HDR0 = 8'hA5;
    localparam logic [7:0] SYNC_HDR1 = 8'h5A;

    localparam int ENTRY_W = 9;

endpackage

// File: rtl/packer_fifo.sv
// rtl/packer_fifo.sv - synchronous circular FIFO with full/empty/level
//
// Purpose: single-clock FIFO holding {marker, byte} entries for frame_packer.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset, empties the FIFO
//   push   in   write din this cycle (ignored when full)
//   din    in   entry to write
//   pop    in   discard the head entry this cycle (ignored when empty)
//   dout   out  head entry (valid when !empty)
//   full   out  no free entries
//   empty  out  no stored entries
//   level  out  number of stored entries, 0..2^DEPTH_LOG2
module packer_fifo
    import frame_packer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = ENTRY_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_push;
    logic                do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // indices with different wrap bits mean full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
        end
    end

endmodule

// File: rtl/frame_packer.sv
// rtl/frame_packer.sv - buffers camera bytes, inserts frame sync header, paces them to a UART
//
// Purpose: absorbs bursty camera bytes into a FIFO, tags the first byte of each
// frame, and hands bytes one at a time to a UART transmitter using a
// start/finish handshake. A two-byte sync header precedes every frame.
// Optional feature: define FRAME_PACKER_CKSUM_EN to emit a modulo-256 sum of the
// previous frame's data bytes ahead of each header after the first frame.
// Ports:
//   sys_clk      in   system clock
//   rst          in   synchronous active-high reset
//   frame_start  in   next accepted byte starts a new frame
//   in_valid     in   in_data is valid this cycle
//   in_data      in   camera byte
//   tx_start     out  request to UART transmitter
//   tx_data      out  byte to transmit, stable while tx_start is high
//   tx_finish    in   transmitter idle flag, asynchronous to sys_clk
//   overflow     out  sticky: a byte was dropped on a full FIFO
//   fifo_level   out  current FIFO occupancy
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 10,
    parameter logic [7:0] HDR0       = SYNC_HDR0,
    parameter logic [7:0] HDR1       = SYNC_HDR1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_finish,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    // Synchroniser for the transmitter's idle flag.
    logic fin_meta_q;
    logic fin_s_q;

    logic pend_mark_q, pend_mark_d;
    logic overflow_q, overflow_d;

    state_e          state_q, state_d;
    // Send queue: entry [0] goes out next; send_cnt_q holds how many remain.
    logic [3:0][7:0] send_q, send_d;
    logic [2:0]      send_cnt_q, send_cnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic                 fifo_pop;
    logic [ENTRY_W-1:0]   fifo_din;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;

`ifdef FRAME_PACKER_CKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       frame_sent_q, frame_sent_d;
`endif

    // A frame_start in the same cycle as the byte marks that byte directly.
    assign fifo_din = {pend_mark_q | frame_start, in_data};
    assign accept   = in_valid && !fifo_full;

    packer_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (in_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Marker survives a dropped byte so the next accepted byte still opens the frame.
    always_comb begin
        pend_mark_d = pend_mark_q;
        overflow_d  = overflow_q;
        if (accept) begin
            pend_mark_d = 1'b0;
        end else if (frame_start) begin
            pend_mark_d = 1'b1;
        end
        if (in_valid && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        send_d     = send_q;
        send_cnt_d = send_cnt_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
`ifdef FRAME_PACKER_CKSUM_EN
        sum_d        = sum_q;
        frame_sent_d = frame_sent_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty && fin_s_q) begin
                    state_d = POP;
                end
            end
            POP: begin
                fifo_pop = 1'b1;
                if (fifo_dout[8]) begin
`ifdef FRAME_PACKER_CKSUM_EN
                    if (frame_sent_q) begin
                        send_d     = {fifo_dout[7:0], HDR1, HDR0, sum_q};
                        send_cnt_d = 3'd4;
                    end else begin
                        send_d     = {8'h00, fifo_dout[7:0], HDR1, HDR0};
                        send_cnt_d = 3'd3;
                    end
                    // New frame: sum restarts with this byte only.
                    sum_d        = fifo_dout[7:0];
                    frame_sent_d = 1'b1;
`else
                    send_d     = {8'h00, fifo_dout[7:0], HDR1, HDR0};
                    send_cnt_d = 3'd3;
`endif
                end else begin
                    send_d     = {24'h000000, fifo_dout[7:0]};
                    send_cnt_d = 3'd1;
`ifdef FRAME_PACKER_CKSUM_EN
                    sum_d = sum_q + fifo_dout[7:0];
`endif
                end
                state_d = SEND;
            end
            SEND: begin
                tx_data_d  = send_q[0];
                tx_start_d = 1'b1;
                send_d     = {8'h00, send_q[3:1]};
                send_cnt_d = send_cnt_q - 3'd1;
                state_d    = ACK;
            end
            ACK: begin
                // Transmitter pulls its idle flag low once it has taken the byte.
                if (!fin_s_q) begin
                    tx_start_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (fin_s_q) begin
                    state_d = (send_cnt_q != 3'd0) ? SEND : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            fin_meta_q  <= 1'b0;
            fin_s_q     <= 1'b0;
            pend_mark_q <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= IDLE;
            send_q      <= '0;
            send_cnt_q  <= 3'd0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            fin_meta_q  <= tx_finish;
            fin_s_q     <= fin_meta_q;
            pend_mark_q <= pend_mark_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            send_q      <= send_d;
            send_cnt_q  <= send_cnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

`ifdef FRAME_PACKER_CKSUM_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sum_q        <= 8'h00;
            frame_sent_q <= 1'b0;
        end else begin
            sum_q        <= sum_d;
            frame_sent_q <= frame_sent_d;
        end
    end
`endif

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;

endmodule
